ecg_peak_filter: RTL and testbench
==================================

ECG_PEAK_FILTER -- requirements
Module: ecg_peak_filter

Interface
REQ-001 Parameter DATA_W, default 8, sample/threshold width in bits; SHALL be a multiple of NIB_W, 8..16.
REQ-002 Parameter NIB_W, default 4, load-bus width in bits.
REQ-003 Parameter HYST, default 4, fall below the running maximum that confirms a peak.
REQ-004 Parameter REFRACT, default 16, refractory length in clk cycles, at least 1.
REQ-005 clk  input  1  clock; all state SHALL update on rising edge only.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 in_data  input  NIB_W  load nibble.
REQ-008 in_valid  input  1  in_data valid this cycle.
REQ-009 in_sel  input  1  target: 0 = sample, 1 = threshold.
REQ-010 in_last  input  1  final nibble of the word; commits the word.
REQ-011 fop  output  DATA_W  last sample that passed the threshold.
REQ-012 fop_valid  output  1  one-cycle pulse per committed sample.
REQ-013 pass  output  1  qualifies fop_valid: committed sample exceeded the threshold.
REQ-014 peak  output  1  one-cycle peak pulse.
REQ-015 peak_val  output  DATA_W  amplitude of the last detected peak.
REQ-016 peak_cnt  output  8  saturating peak counter.
REQ-017 refr  output  1  high while in REFRACT.

Function
REQ-018 Each in_valid cycle SHALL shift in_data into the assembly register, MSB-first: asm <= {asm[DATA_W-NIB_W-1:0], in_data}.
- Extra nibbles SHALL drop the oldest.
- Short words SHALL zero-extend, because asm is cleared after commit.
REQ-019 in_valid & in_last SHALL commit the shifted word on that edge (edge N) and clear asm.
- in_sel=1: the word goes to th.
- in_sel=0: the word goes to the sample register and marks a sample event.
REQ-020 For a sample committed at edge N, edge N+1 SHALL pulse fop_valid, with pass = (sample > th).
- Comparison is unsigned and strictly greater.
- If pass is 1, fop SHALL load the sample; otherwise fop holds.
REQ-021 A threshold committed at edge N SHALL apply only to samples committed after edge N.
REQ-022 The peak FSM SHALL act at edge N+2 and has states IDLE, RISING, REFRACT.
REQ-023 IDLE: a passing sample SHALL set max <= sample and move to RISING.
REQ-024 RISING: a passing sample with sample > max SHALL update max.
- Any sample with pass=0 SHALL confirm the peak.
- Any sample with sample <= max-HYST (floor 0, saturating) SHALL confirm the peak.
- On confirm: peak pulses one cycle, peak_val <= max, peak_cnt increments (saturating at 255), counter <= REFRACT, state -> REFRACT.
REQ-025 REFRACT: the counter SHALL decrement every clk and ignore samples; at count 1 the state goes to IDLE, so the dwell is exactly REFRACT cycles.
- fop and fop_valid SHALL continue normally during REFRACT.
REQ-026 Back-to-back sample commits, one per cycle, SHALL be processed with no loss.

Reset
REQ-027 While rst=0, all registers SHALL clear: asm, th, sample, fop, fop_valid, pass, peak, peak_val, peak_cnt, max, counter, refr = 0, FSM = IDLE.
REQ-028 Reset mid-word SHALL discard the partial nibbles; reset during REFRACT SHALL abort to IDLE.
REQ-029 Deassertion SHALL take effect on the first rising clk after rst rises; no output pulses on that edge.

Structure
REQ-030 Package ecg_pkg SHALL hold the FSM state enum (IDLE, RISING, REFRACT) and the default constants DATA_W=8, NIB_W=4, HYST=4, REFRACT=16.
REQ-031 The nibble-assembly logic SHALL be one sub-module, nib_loader (in_data/in_valid/in_last -> word, commit strobe); the filter and FSM remain in the top.

Verification
REQ-032 Scenario: load th=0x40 (nibbles 4,0), then sample 0x55 -> fop=0x55, fop_valid=1, pass=1 at edge N+1.
REQ-033 Scenario: th=0x40, sample 0x40 -> pass=0, fop unchanged, no state change.
REQ-034 Scenario: th=0x20, samples 0x30, 0x50, 0x60, 0x5C -> peak at N+2 of 0x5C, peak_val=0x60, peak_cnt=1, refr high exactly 16 cycles.
REQ-035 Scenario: a second rise 0x70, 0x60 during REFRACT -> no peak; after REFRACT a new rise 0x70, 0x60 -> peak_cnt=2.
REQ-036 Scenario: 256 peaks -> peak_cnt saturates at 255.
REQ-037 Scenario: assert rst mid-word and during REFRACT -> all outputs 0, FSM IDLE, next full word loads correctly.

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared constants and FSM state type for the ECG peak filter.
package ecg_pkg;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_NIB_W   = 4;
   localparam int DEF_HYST    = 4;
   localparam int DEF_REFRACT = 16;
   localparam int PEAK_CNT_W  = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RISING  = 2'd1,
      S_REFRACT = 2'd2
   } peak_state_t;
endpackage

// File: rtl/ecg_peak_filter_if.sv
// Nibble load bus and filter/peak result signals of the ECG peak filter.
interface ecg_peak_filter_if
   import ecg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NIB_W  = DEF_NIB_W
);
   logic [NIB_W-1:0]      in_data;
   logic                  in_valid;
   logic                  in_sel;
   logic                  in_last;
   logic [DATA_W-1:0]     fop;
   logic                  fop_valid;
   logic                  pass;
   logic                  peak;
   logic [DATA_W-1:0]     peak_val;
   logic [PEAK_CNT_W-1:0] peak_cnt;
   logic                  refr;

   modport master (
      output in_data, in_valid, in_sel, in_last,
      input  fop, fop_valid, pass, peak, peak_val, peak_cnt, refr
   );

   modport slave (
      input  in_data, in_valid, in_sel, in_last,
      output fop, fop_valid, pass, peak, peak_val, peak_cnt, refr
   );
endinterface

// File: rtl/ecg_peak_filter_nib_loader.sv
// Assembles MSB-first nibbles into a word; commit strobe and word are valid on the last nibble.
module nib_loader #(
   parameter int DATA_W = 8,
   parameter int NIB_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NIB_W-1:0]  in_data_i,
   input  logic              in_valid_i,
   input  logic              in_last_i,
   output logic [DATA_W-1:0] word_o,
   output logic              commit_o
);
   logic [DATA_W-1:0] asm_q, asm_d, shifted;

   // Oldest nibble falls off the top; cleared after commit so short words zero-extend.
   assign shifted  = (asm_q << NIB_W) | DATA_W'(in_data_i);
   assign word_o   = shifted;
   assign commit_o = in_valid_i & in_last_i;

   always_comb begin
      asm_d = asm_q;
      if (in_valid_i) begin
         asm_d = in_last_i ? '0 : shifted;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) asm_q <= '0;
      else      asm_q <= asm_d;
   end
endmodule

// File: rtl/ecg_peak_filter.sv
// ECG peak filter: threshold gate on committed samples, then peak detection with refractory dwell.
//   state     | meaning
//   S_IDLE    | waiting for a sample above threshold
//   S_RISING  | tracking the running maximum of a rise
//   S_REFRACT | refractory dwell after a peak, samples ignored
module ecg_peak_filter
   import ecg_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int NIB_W   = DEF_NIB_W,
   parameter int HYST    = DEF_HYST,
   parameter int REFRACT = DEF_REFRACT
) (
   input logic              clk,
   input logic              rst,
   ecg_peak_filter_if.slave bus
);
   localparam int CNT_W   = $clog2(REFRACT + 1);
   localparam int HYST_CL = (HYST > (2**DATA_W) - 1) ? (2**DATA_W) - 1 : HYST;
   localparam logic [DATA_W-1:0] HYST_V  = DATA_W'(HYST_CL);
   localparam logic [CNT_W-1:0]  REFR_V  = CNT_W'(REFRACT);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   if ((DATA_W % NIB_W) != 0 || DATA_W < 8 || DATA_W > 16) begin : g_bad_width
      $error("DATA_W must be a multiple of NIB_W within 8..16");
   end
   if (REFRACT < 1) begin : g_bad_refract
      $error("REFRACT must be at least 1");
   end

   logic [DATA_W-1:0]     word;
   logic                  commit;
   logic [DATA_W-1:0]     th_q, sample_q, samp_d1_q, fop_q;
   logic                  samp_ev_q, fop_valid_q, pass_q;
   peak_state_t           state_q, state_d;
   logic [DATA_W-1:0]     max_q, max_d, max_floor;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  confirm;
   logic                  peak_q, refr_q;
   logic [DATA_W-1:0]     peak_val_q;
   logic [PEAK_CNT_W-1:0] peak_cnt_q;

   nib_loader #(.DATA_W(DATA_W), .NIB_W(NIB_W)) u_nib_loader (
      .clk        (clk),
      .rst        (rst),
      .in_data_i  (bus.in_data),
      .in_valid_i (bus.in_valid),
      .in_last_i  (bus.in_last),
      .word_o     (word),
      .commit_o   (commit)
   );

   // Threshold gate one edge after commit; the compare sees th_q from before that edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         th_q        <= '0;
         sample_q    <= '0;
         samp_ev_q   <= 1'b0;
         samp_d1_q   <= '0;
         fop_q       <= '0;
         fop_valid_q <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         samp_ev_q   <= commit & ~bus.in_sel;
         if (commit && bus.in_sel)  th_q     <= word;
         if (commit && !bus.in_sel) sample_q <= word;
         fop_valid_q <= samp_ev_q;
         samp_d1_q   <= sample_q;
         if (samp_ev_q) begin
            pass_q <= (sample_q > th_q);
            if (sample_q > th_q) fop_q <= sample_q;
         end
      end
   end

   assign max_floor = (max_q > HYST_V) ? (max_q - HYST_V) : '0;

   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      confirm = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fop_valid_q && pass_q) begin
               max_d   = samp_d1_q;
               state_d = S_RISING;
            end
         end
         S_RISING: begin
            if (fop_valid_q) begin
               if (!pass_q || (samp_d1_q <= max_floor)) begin
                  confirm = 1'b1;
                  cnt_d   = REFR_V;
                  state_d = S_REFRACT;
               end else if (samp_d1_q > max_q) begin
                  max_d = samp_d1_q;
               end
            end
         end
         S_REFRACT: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         max_q      <= '0;
         cnt_q      <= '0;
         peak_q     <= 1'b0;
         peak_val_q <= '0;
         peak_cnt_q <= '0;
         refr_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
         peak_q  <= confirm;
         refr_q  <= (state_d == S_REFRACT);
         if (confirm) begin
            peak_val_q <= max_q;
            if (peak_cnt_q != {PEAK_CNT_W{1'b1}}) peak_cnt_q <= peak_cnt_q + 1'b1;
         end
      end
   end

   assign bus.fop       = fop_q;
   assign bus.fop_valid = fop_valid_q;
   assign bus.pass      = pass_q;
   assign bus.peak      = peak_q;
   assign bus.peak_val  = peak_val_q;
   assign bus.peak_cnt  = peak_cnt_q;
   assign bus.refr      = refr_q;
endmodule

// File: tb/tb_ecg_peak_filter.sv
// Bench for ecg_peak_filter: directed scenarios plus random traffic against an event-timed model.
module tb_ecg_peak_filter;
   localparam int DW = 8;
   localparam int NW = 4;
   localparam int HY = 4;
   localparam int RF = 16;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   ecg_peak_filter_if #(.DATA_W(DW), .NIB_W(NW)) bus ();

   ecg_peak_filter #(.DATA_W(DW), .NIB_W(NW), .HYST(HY), .REFRACT(RF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each committed sample becomes two timed events, a gate result one
   // edge later and a detector decision two edges later; refractory is a time window.
   typedef struct { int due; int val; bit ps; } ev_t;
   ev_t fq[$];
   ev_t sq[$];
   int  ecnt = 0, m_asm = 0, m_th = 0, m_fop = 0, m_peak_val = 0, m_peak_cnt = 0;
   int  m_max = 0, m_refr_end = -1, floor_v = 0;
   bit  m_fop_valid = 0, m_pass = 0, m_peak = 0, m_rising = 0, m_refr = 0;

   initial begin : ref_model
      ev_t e;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            fq.delete(); sq.delete();
            m_asm = 0; m_th = 0; m_fop = 0; m_peak_val = 0; m_peak_cnt = 0; m_max = 0;
            m_refr_end = -1; m_fop_valid = 0; m_pass = 0; m_peak = 0; m_rising = 0; m_refr = 0;
         end else begin
            ecnt++;
            m_fop_valid = 0;
            m_peak = 0;
            while (fq.size() > 0 && fq[0].due == ecnt) begin
               e = fq.pop_front();
               m_fop_valid = 1;
               m_pass = e.ps;
               if (e.ps) m_fop = e.val;
            end
            while (sq.size() > 0 && sq[0].due == ecnt) begin
               e = sq.pop_front();
               if (ecnt > m_refr_end) begin
                  if (!m_rising) begin
                     if (e.ps) begin m_rising = 1; m_max = e.val; end
                  end else begin
                     floor_v = (m_max > HY) ? m_max - HY : 0;
                     if (!e.ps || e.val <= floor_v) begin
                        m_peak = 1;
                        m_peak_val = m_max;
                        if (m_peak_cnt < 255) m_peak_cnt++;
                        m_rising = 0;
                        m_refr_end = ecnt + RF;
                     end else if (e.val > m_max) begin
                        m_max = e.val;
                     end
                  end
               end
            end
            m_refr = (ecnt < m_refr_end);
            if (bus.in_valid) begin
               m_asm = ((m_asm << NW) | int'(bus.in_data)) & ((1 << DW) - 1);
               if (bus.in_last) begin
                  if (bus.in_sel) m_th = m_asm;
                  else begin
                     e.val = m_asm; e.ps = (m_asm > m_th);
                     e.due = ecnt + 1; fq.push_back(e);
                     e.due = ecnt + 2; sq.push_back(e);
                  end
                  m_asm = 0;
               end
            end
         end
      end
   end

   int peaks_seen = 0, refr_run = 0, last_refr_run = 0;
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (bus.peak === 1'b1) peaks_seen++;
         if (bus.refr === 1'b1) refr_run++;
         else begin
            if (refr_run > 0) last_refr_run = refr_run;
            refr_run = 0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      failures++;
      $display("FAIL watchdog: time limit reached, required end of tests");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   task automatic bus_idle();
      bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
   endtask

   task automatic send_word(input bit sel, input int val, input int nnib);
      for (int i = nnib - 1; i >= 0; i--) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_sel   = sel;
         bus.in_last  = (i == 0);
         bus.in_data  = NW'((val >> (i * NW)) & ((1 << NW) - 1));
      end
      @(negedge clk);
      bus_idle();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus_idle();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_refr_low(output bit ok);
      int n = 0;
      while (bus.refr === 1'b1 && n < 64) begin @(negedge clk); n++; end
      ok = (n < 64);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++; if (bus.fop !== 8'h00)      begin failures++; $display("FAIL rst_fop: got %h exp 00", bus.fop); end
      checks++; if (bus.fop_valid !== 1'b0) begin failures++; $display("FAIL rst_fop_valid: got %b exp 0", bus.fop_valid); end
      checks++; if (bus.pass !== 1'b0)      begin failures++; $display("FAIL rst_pass: got %b exp 0", bus.pass); end
      checks++; if (bus.peak !== 1'b0)      begin failures++; $display("FAIL rst_peak: got %b exp 0", bus.peak); end
      checks++; if (bus.peak_val !== 8'h00) begin failures++; $display("FAIL rst_peak_val: got %h exp 00", bus.peak_val); end
      checks++; if (bus.peak_cnt !== 8'h00) begin failures++; $display("FAIL rst_peak_cnt: got %0d exp 0", bus.peak_cnt); end
      checks++; if (bus.refr !== 1'b0)      begin failures++; $display("FAIL rst_refr: got %b exp 0", bus.refr); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (bus.fop_valid !== 1'b0 || bus.peak !== 1'b0) begin
         failures++; $display("FAIL rst_release_pulse: fop_valid=%b peak=%b exp 0 0", bus.fop_valid, bus.peak);
      end
   endtask

   task automatic test_no_pass();
      send_word(1'b1, 'h40, 2);
      send_word(1'b0, 'h40, 2);
      @(negedge clk);
      checks++; if (bus.fop_valid !== 1'b1) begin failures++; $display("FAIL nopass_valid: got %b exp 1", bus.fop_valid); end
      checks++; if (bus.pass !== 1'b0)      begin failures++; $display("FAIL nopass_pass: got %b exp 0", bus.pass); end
      checks++; if (bus.fop !== 8'h00)      begin failures++; $display("FAIL nopass_fop: got %h exp 00", bus.fop); end
      @(negedge clk);
      checks++; if (bus.peak !== 1'b0 || bus.refr !== 1'b0) begin
         failures++; $display("FAIL nopass_fsm: peak=%b refr=%b exp 0 0", bus.peak, bus.refr);
      end
   endtask

   task automatic test_pass();
      send_word(1'b0, 'h55, 2);
      @(negedge clk);
      checks++; if (bus.fop_valid !== 1'b1) begin failures++; $display("FAIL pass_valid: got %b exp 1", bus.fop_valid); end
      checks++; if (bus.pass !== 1'b1)      begin failures++; $display("FAIL pass_pass: got %b exp 1", bus.pass); end
      checks++; if (bus.fop !== 8'h55)      begin failures++; $display("FAIL pass_fop: got %h exp 55", bus.fop); end
      @(negedge clk);
      checks++; if (bus.fop_valid !== 1'b0) begin failures++; $display("FAIL pass_pulse_width: got %b exp 0", bus.fop_valid); end
   endtask

   task automatic test_reset_midword();
      do_reset();
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_sel = 1'b0; bus.in_last = 1'b0; bus.in_data = 4'hA;
      @(negedge clk);
      bus_idle();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.fop !== 8'h00 || bus.fop_valid !== 1'b0) begin
         failures++; $display("FAIL midword_rst_out: fop=%h valid=%b exp 00 0", bus.fop, bus.fop_valid);
      end
      rst = 1'b1;
      send_word(1'b0, 'h7, 1);
      @(negedge clk);
      checks++; if (bus.fop !== 8'h07) begin failures++; $display("FAIL midword_next_word: got %h exp 07", bus.fop); end
   endtask

   task automatic test_peak();
      int base;
      do_reset();
      base = peaks_seen;
      send_word(1'b1, 'h20, 2);
      send_word(1'b0, 'h30, 2);
      send_word(1'b0, 'h50, 2);
      send_word(1'b0, 'h60, 2);
      checks++; if (peaks_seen != base) begin failures++; $display("FAIL peak_early: got %0d peaks exp 0", peaks_seen - base); end
      send_word(1'b0, 'h5C, 2);
      @(negedge clk);
      checks++; if (bus.peak !== 1'b0) begin failures++; $display("FAIL peak_n1: got %b exp 0", bus.peak); end
      @(negedge clk);
      checks++; if (bus.peak !== 1'b1)      begin failures++; $display("FAIL peak_pulse: got %b exp 1", bus.peak); end
      checks++; if (bus.peak_val !== 8'h60) begin failures++; $display("FAIL peak_val: got %h exp 60", bus.peak_val); end
      checks++; if (bus.peak_cnt !== 8'd1)  begin failures++; $display("FAIL peak_cnt: got %0d exp 1", bus.peak_cnt); end
      checks++; if (bus.refr !== 1'b1)      begin failures++; $display("FAIL peak_refr: got %b exp 1", bus.refr); end
   endtask

   task automatic test_refract_ignore();
      bit ok;
      int base;
      base = peaks_seen;
      send_word(1'b0, 'h70, 2);
      send_word(1'b0, 'h60, 2);
      wait_refr_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL refr_timeout: refr still high, exp low"); end
      checks++; if (last_refr_run != RF) begin failures++; $display("FAIL refr_len: got %0d exp %0d", last_refr_run, RF); end
      checks++; if (bus.peak_cnt !== 8'd1 || peaks_seen != base) begin
         failures++; $display("FAIL refr_ignored: cnt=%0d new_peaks=%0d exp 1 0", bus.peak_cnt, peaks_seen - base);
      end
      send_word(1'b0, 'h70, 2);
      send_word(1'b0, 'h60, 2);
      repeat (2) @(negedge clk);
      checks++; if (bus.peak !== 1'b1)      begin failures++; $display("FAIL second_peak: got %b exp 1", bus.peak); end
      checks++; if (bus.peak_cnt !== 8'd2)  begin failures++; $display("FAIL second_cnt: got %0d exp 2", bus.peak_cnt); end
      checks++; if (bus.peak_val !== 8'h70) begin failures++; $display("FAIL second_val: got %h exp 70", bus.peak_val); end
   endtask

   task automatic test_reset_refract();
      bit ok;
      checks++; if (bus.refr !== 1'b1) begin failures++; $display("FAIL pre_rst_refr: got %b exp 1", bus.refr); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.refr !== 1'b0 || bus.peak_cnt !== 8'd0 || bus.peak_val !== 8'h00 || bus.fop !== 8'h00) begin
         failures++;
         $display("FAIL refr_rst_out: refr=%b cnt=%0d val=%h fop=%h exp 0 0 00 00", bus.refr, bus.peak_cnt, bus.peak_val, bus.fop);
      end
      rst = 1'b1;
      send_word(1'b1, 'h20, 2);
      send_word(1'b0, 'h30, 2);
      send_word(1'b0, 'h10, 2);
      repeat (2) @(negedge clk);
      checks++; if (bus.peak !== 1'b1 || bus.peak_cnt !== 8'd1 || bus.peak_val !== 8'h30) begin
         failures++; $display("FAIL refr_rst_idle: peak=%b cnt=%0d val=%h exp 1 1 30", bus.peak, bus.peak_cnt, bus.peak_val);
      end
      wait_refr_low(ok);
      checks++; if (!ok) begin failures++; $display("FAIL refr_rst_timeout: refr still high, exp low"); end
   endtask

   task automatic test_back_to_back();
      int vals[4]  = '{3, 5, 0, 9};
      int efop[4]  = '{3, 5, 5, 9};
      bit epass[4] = '{1, 1, 0, 1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (bus.fop_valid !== 1'b1 || bus.pass !== epass[i-2] || bus.fop !== 8'(efop[i-2])) begin
               failures++;
               $display("FAIL b2b_%0d: valid=%b pass=%b fop=%h exp 1 %b %h", i - 2, bus.fop_valid, bus.pass, bus.fop, epass[i-2], 8'(efop[i-2]));
            end
         end
         if (i == 5) begin
            checks++; if (bus.peak !== 1'b1 || bus.peak_val !== 8'h05) begin
               failures++; $display("FAIL b2b_peak: peak=%b val=%h exp 1 05", bus.peak, bus.peak_val);
            end
         end
         if (i < 4) begin
            bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_sel = 1'b0; bus.in_data = NW'(vals[i]);
         end else bus_idle();
      end
      repeat (RF + 4) @(negedge clk);
   endtask

   task automatic test_saturate();
      bit ok;
      bit all_ok = 1;
      int expc;
      do_reset();
      send_word(1'b1, 'h20, 2);
      for (int k = 0; k < 260; k++) begin
         send_word(1'b0, 'h80, 2);
         send_word(1'b0, 'h10, 2);
         repeat (2) @(negedge clk);
         expc = (k + 1 > 255) ? 255 : k + 1;
         checks++; if (bus.peak_cnt !== 8'(expc)) begin
            failures++; $display("FAIL sat_cnt_%0d: got %0d exp %0d", k, bus.peak_cnt, expc);
         end
         wait_refr_low(ok);
         all_ok &= ok;
      end
      checks++; if (!all_ok) begin failures++; $display("FAIL sat_timeout: refr stuck high, exp low"); end
   endtask

   task automatic test_random();
      int prints = 0;
      bit bad;
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         bad = 0;
         checks++; if (bus.fop_valid !== m_fop_valid) bad = 1;
         checks++; if (bus.fop !== DW'(m_fop)) bad = 1;
         checks++; if (m_fop_valid && bus.pass !== m_pass) bad = 1;
         checks++; if (bus.peak !== m_peak) bad = 1;
         checks++; if (bus.peak_val !== DW'(m_peak_val)) bad = 1;
         checks++; if (bus.peak_cnt !== 8'(m_peak_cnt)) bad = 1;
         checks++; if (bus.refr !== m_refr) bad = 1;
         if (bad) begin
            failures++;
            if (prints < 20) begin
               prints++;
               $display("FAIL rand_cycle_%0d: got v=%b f=%h p=%b pk=%b pv=%h pc=%0d r=%b exp v=%b f=%h p=%b pk=%b pv=%h pc=%0d r=%b",
                        c, bus.fop_valid, bus.fop, bus.pass, bus.peak, bus.peak_val, bus.peak_cnt, bus.refr,
                        m_fop_valid, DW'(m_fop), m_pass, m_peak, DW'(m_peak_val), m_peak_cnt, m_refr);
            end
         end
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.in_last  = ($urandom_range(0, 2) == 0);
         bus.in_sel   = ($urandom_range(0, 7) == 0);
         bus.in_data  = NW'($urandom_range(0, (1 << NW) - 1));
      end
      @(negedge clk);
      bus_idle();
   endtask

   initial begin : main
      rst = 1'b0;
      bus_idle();
      test_reset();
      test_no_pass();
      test_pass();
      test_reset_midword();
      test_peak();
      test_refract_ignore();
      test_reset_refract();
      test_back_to_back();
      test_saturate();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
